jk_bank_sequencer: RTL
======================

# jk_bank_sequencer

Command sequencer and two-port arbiter for a WIDTH-bit bank of JK flip-flop cells. Two requesters submit bank commands: clear, set, toggle, load, or multi-cycle synchronous count. The block grants one requester at a time and drives the bank's per-bit J/K inputs cycle by cycle until the command completes. It sits between the control plane and the JK register bank, using the bank's Q outputs as feedback for counting.

## Interface
Parameters:
- WIDTH, 8, number of JK cells in the bank
- CNT_W, 8, width of the count-length argument (COUNT ops use arg[CNT_W-1:0])

Ports:
- clk  in  1  clock; the bank is clocked on the same edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester command valid; held high until accepted
- req_ready  out  2  per-requester grant/accept; one-hot or zero
- req_op  in  2x3  per-requester opcode, packed {op1, op0}
- req_arg  in  2xWIDTH  per-requester argument/mask, packed {arg1, arg0}
- q  in  WIDTH  current bank Q outputs (feedback)
- j  out  WIDTH  J inputs to the bank
- k  out  WIDTH  K inputs to the bank
- busy  out  1  high while a command is executing (state != IDLE)
- done  out  1  one-cycle pulse in the final drive cycle of a command
- done_id  out  1  requester index of the completing command; valid with done

## Operation
- Opcodes, with arg as mask M or value V. Unmasked bits get j=k=0 (hold).
  - 0 NOP: j=k=0.
  - 1 CLEAR: j=0, k=M.
  - 2 SET: j=M, k=0.
  - 3 TOGGLE: j=k=M.
  - 4 LOAD: j=V, k=~V on all bits.
  - 5 COUNT_UP N: N cycles of synchronous increment. For i>0, j[i]=k[i]=&q[i-1:0]; j[0]=k[0]=1.
  - 6 COUNT_DOWN N: same as COUNT_UP using &~q[i-1:0].
  - 7 reserved: executes as NOP.
- COUNT wraps naturally at all-ones/all-zeros, with no saturation. N=0 executes one cycle with j=k=0.
- FSM states:
  - IDLE: arbitrate. On accept (valid&ready), capture op, arg, and requester id, then go to EXEC (ops 0–4, 7) or COUNT (ops 5–6, N>0; N=0 goes to EXEC).
  - EXEC: one drive cycle with done=1, then IDLE.
  - COUNT: remaining counter loads N and decrements each cycle. done=1 when remaining==1, then IDLE.
- Arbitration is round-robin, evaluated only in IDLE.
  - If one requester is valid, it is granted.
  - If both are valid, the one not granted last time wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- req_ready is combinational from state, req_valid, and last_grant. It is zero outside IDLE. Dropping valid before ready is a protocol violation and its behaviour is undefined.
- j/k are combinational from captured op/arg, state, and q. They are 0 in IDLE.

## Timing
- Reset values: j=0, k=0, req_ready=0, busy=0, done=0, done_id=0, state=IDLE, last_grant=1.
- Accept at edge T. Drive cycles start at T and span [T, T+L). L=1 for EXEC and L=N for COUNT. The bank updates at each edge T+1..T+L.
- The next accept is possible at edge T+L+1 (one IDLE cycle between commands). Minimum command period is L+1 cycles.
- busy is high for exactly L cycles. done is high only in the last of them, coincident with the final bank update.
- rst mid-command aborts immediately: j/k return to 0 and no done pulse is issued. The bank is reset by the same rst.
- A valid asserted while busy waits. It is granted in the first IDLE cycle according to round-robin.

## Test plan
- Reset, then requester 0 issues LOAD 0xA5. Expect ready0 in the first cycle, j=0xA5 and k=0x5A for one cycle, q=0xA5 after, done=1 with done_id=0.
- With q=0xF0: SET 0x0F → q=0xFF. CLEAR 0x81 → q=0x7E. TOGGLE 0xFF → q=0x81. Each has busy for 1 cycle.
- LOAD 0xFD, then COUNT_UP N=4. Expect q sequence 0xFE, 0xFF, 0x00, 0x01 (wrap), busy for 4 cycles, done only in the 4th.
- LOAD 0x01, then COUNT_DOWN N=2 → q=0x00, then 0xFF. COUNT_UP N=0 → q unchanged, done after 1 cycle.
- Both requesters hold valid continuously with different LOADs. Grants alternate 0, 1, 0, 1 with one IDLE cycle between commands, and done_id matches each grant.
- Assert rst during cycle 2 of COUNT_UP N=5. Expect j=k=0, busy=0, no done pulse, and requester 0 winning the next contention.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//
// Command sequencer and two-port round-robin arbiter for a WIDTH-bit bank of
// JK flip-flop cells. One requester is granted at a time. The accepted
// command (clear / set / toggle / load / N-cycle count) is turned into
// per-bit J/K drive, cycle by cycle, until it completes. Counting uses the
// bank's Q outputs as feedback.
//
// Ports
//   clk          clock; the JK bank is clocked on the same edge
//   rst          asynchronous, active-high reset
//   req_valid_i  [1:0]          per-requester command valid (held until accepted)
//   req_ready_o  [1:0]          per-requester grant; one-hot or zero, IDLE only
//   req_op_i     [5:0]          opcodes, packed {op1, op0}
//   req_arg_i    [2*WIDTH-1:0]  mask/value/count, packed {arg1, arg0}
//   q_i          [WIDTH-1:0]    bank Q feedback
//   j_o, k_o     [WIDTH-1:0]    bank J/K drive; zero while idle
//   busy_o                      a command is executing
//   done_o                      pulse in the final drive cycle of a command
//   done_id_o                   requester index of the completing command

`timescale 1ns/1ps

module jk_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [5:0]         req_op_i,
  input  logic [2*WIDTH-1:0] req_arg_i,
  input  logic [WIDTH-1:0]   q_i,
  output logic [WIDTH-1:0]   j_o,
  output logic [WIDTH-1:0]   k_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               done_id_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_COUNT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_LOAD   = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   arg_q, arg_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               last_grant_q, last_grant_d;

  logic               grant_id;
  logic               accept;
  op_e                sel_op;
  logic [WIDTH-1:0]   sel_arg;
  logic [CNT_W-1:0]   sel_n;
  logic               sel_is_count;
  logic [WIDTH-1:0]   carry_up;
  logic [WIDTH-1:0]   borrow_dn;

  // Round-robin arbitration, only meaningful in IDLE. On contention the
  // requester that was not granted last time wins.
  always_comb begin
    grant_id    = 1'b0;
    req_ready_o = 2'b00;
    if (state_q == S_IDLE) begin
      unique case (req_valid_i)
        2'b01:   grant_id = 1'b0;
        2'b10:   grant_id = 1'b1;
        2'b11:   grant_id = ~last_grant_q;
        default: grant_id = 1'b0;
      endcase
      if (req_valid_i != 2'b00) begin
        req_ready_o = grant_id ? 2'b10 : 2'b01;
      end
    end
  end

  assign accept  = |req_ready_o;
  assign sel_op  = op_e'(grant_id ? req_op_i[5:3] : req_op_i[2:0]);
  assign sel_arg = grant_id ? req_arg_i[2*WIDTH-1:WIDTH] : req_arg_i[WIDTH-1:0];

  // Count length comes from the low CNT_W bits of the argument; if the count
  // field is wider than the bank it is zero-extended.
  if (CNT_W <= WIDTH) begin : g_n_narrow
    assign sel_n = sel_arg[CNT_W-1:0];
  end else begin : g_n_wide
    assign sel_n = {{(CNT_W-WIDTH){1'b0}}, sel_arg};
  end

  // A zero-length count behaves as a single idle drive cycle through EXEC.
  assign sel_is_count = ((sel_op == OP_CNT_UP) || (sel_op == OP_CNT_DN)) &&
                        (sel_n != '0);

  // State and captured-command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      arg_q        <= '0;
      id_q         <= 1'b0;
      remaining_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      id_q         <= id_d;
      remaining_q  <= remaining_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    id_d         = id_q;
    remaining_d  = remaining_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d         = sel_op;
          arg_d        = sel_arg;
          id_d         = grant_id;
          last_grant_d = grant_id;
          if (sel_is_count) begin
            state_d     = S_COUNT;
            remaining_d = sel_n;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
      end
      S_COUNT: begin
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Ripple enables for a synchronous counter built from JK cells: bit i
  // toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
  always_comb begin
    carry_up     = '0;
    borrow_dn    = '0;
    carry_up[0]  = 1'b1;
    borrow_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry_up[i]  = carry_up[i-1]  &  q_i[i-1];
      borrow_dn[i] = borrow_dn[i-1] & ~q_i[i-1];
    end
  end

  // J/K drive and status outputs.
  always_comb begin
    j_o = '0;
    k_o = '0;
    unique case (state_q)
      S_EXEC: begin
        unique case (op_q)
          OP_CLEAR: begin
            k_o = arg_q;
          end
          OP_SET: begin
            j_o = arg_q;
          end
          OP_TOGGLE: begin
            j_o = arg_q;
            k_o = arg_q;
          end
          OP_LOAD: begin
            j_o = arg_q;
            k_o = ~arg_q;
          end
          default: begin
            j_o = '0;
            k_o = '0;
          end
        endcase
      end
      S_COUNT: begin
        if (op_q == OP_CNT_DN) begin
          j_o = borrow_dn;
          k_o = borrow_dn;
        end else begin
          j_o = carry_up;
          k_o = carry_up;
        end
      end
      default: begin
        j_o = '0;
        k_o = '0;
      end
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_EXEC) ||
                     ((state_q == S_COUNT) && (remaining_q == CNT_ONE));
  assign done_id_o = id_q;

endmodule
